// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: each channel divides the shared prescaler tick by
// RELOAD+1 and pulses its ch_tick bit on expiry, periodic or one-shot, with optional IRQ.
module tick_scheduler #(
   parameter int NCH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tick_in,
   input  logic                   wr,
   input  logic                   rd,
   input  logic [$clog2(NCH)+1:0] addr,
   input  logic [7:0]             wdata,
   output logic [7:0]             rdata,
   output logic [NCH-1:0]         ch_tick,
   output logic                   irq
);
   localparam int AW = $clog2(NCH) + 2;

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

   state_e                state_q [NCH];
   state_e                state_d [NCH];
   logic [NCH-1:0][15:0]  reload_q, reload_d;
   logic [NCH-1:0][15:0]  cnt_q, cnt_d;
   logic [NCH-1:0]        oneshot_q, oneshot_d;
   logic [NCH-1:0]        ie_q, ie_d;
   logic [NCH-1:0]        expired_q, expired_d;
   logic [NCH-1:0]        ch_tick_q, ch_tick_d;
   logic                  irq_q, irq_d;
   logic [7:0]            rdata_q, rdata_d;
   logic [7:0]            rd_val;
   logic [AW-1:0]         ch_sel;
   logic [1:0]            reg_sel;
   logic [NCH-1:0]        sel;

   // Channel indices >= NCH match no sel bit, so they are write-ignored and read 0.
   assign ch_sel  = addr >> 2;
   assign reg_sel = addr[1:0];

   always_comb begin
      sel = '0;
      for (int i = 0; i < NCH; i++) sel[i] = (ch_sel == AW'(i));
   end

   always_comb begin
      rd_val = 8'h00;
      for (int i = 0; i < NCH; i++) begin
         if (sel[i]) begin
            case (reg_sel)
               2'd0:    rd_val = reload_q[i][7:0];
               2'd1:    rd_val = reload_q[i][15:8];
               2'd2:    rd_val = {5'b0, ie_q[i], oneshot_q[i], state_q[i] == ST_RUN};
               default: rd_val = {7'b0, expired_q[i]};
            endcase
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         state_d[i]   = state_q[i];
         reload_d[i]  = reload_q[i];
         cnt_d[i]     = cnt_q[i];
         oneshot_d[i] = oneshot_q[i];
         ie_d[i]      = ie_q[i];
         ch_tick_d[i] = 1'b0;
         // W1C is applied first so a same-cycle expiry below wins.
         expired_d[i] = expired_q[i] & ~(wr && sel[i] && reg_sel == 2'd3 && wdata[0]);

         // A disabling CTRL write swallows an expiry landing in the same cycle.
         if (state_q[i] == ST_RUN && tick_in &&
             !(wr && sel[i] && reg_sel == 2'd2 && !wdata[0])) begin
            if (cnt_q[i] != 16'd0) begin
               cnt_d[i] = cnt_q[i] - 16'd1;
            end else begin
               ch_tick_d[i] = 1'b1;
               expired_d[i] = 1'b1;
               if (oneshot_q[i]) state_d[i] = ST_IDLE;
               else              cnt_d[i]   = reload_q[i];
            end
         end

         if (wr && sel[i]) begin
            case (reg_sel)
               2'd0: reload_d[i][7:0]  = wdata;
               2'd1: reload_d[i][15:8] = wdata;
               2'd2: begin
                  oneshot_d[i] = wdata[1];
                  ie_d[i]      = wdata[2];
                  if (!wdata[0]) begin
                     state_d[i] = ST_IDLE;
                  end else if (state_q[i] == ST_IDLE) begin
                     state_d[i] = ST_RUN;
                     cnt_d[i]   = reload_q[i];
                  end
               end
               default: ;
            endcase
         end
      end

      irq_d   = |(expired_q & ie_q);
      rdata_d = rd ? rd_val : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) state_q[i] <= ST_IDLE;
         reload_q  <= '0;
         cnt_q     <= '0;
         oneshot_q <= '0;
         ie_q      <= '0;
         expired_q <= '0;
         ch_tick_q <= '0;
         irq_q     <= 1'b0;
         rdata_q   <= 8'h00;
      end else begin
         for (int i = 0; i < NCH; i++) state_q[i] <= state_d[i];
         reload_q  <= reload_d;
         cnt_q     <= cnt_d;
         oneshot_q <= oneshot_d;
         ie_q      <= ie_d;
         expired_q <= expired_d;
         ch_tick_q <= ch_tick_d;
         irq_q     <= irq_d;
         rdata_q   <= rdata_d;
      end
   end

   assign rdata   = rdata_q;
   assign ch_tick = ch_tick_q;
   assign irq     = irq_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a behavioural per-channel model.
module tb_tick_scheduler;
   localparam int NCH = 4;
   localparam int AW  = $clog2(NCH) + 2;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           tick_in = 1'b0;
   logic           wr = 1'b0;
   logic           rd = 1'b0;
   logic [AW-1:0]  addr = '0;
   logic [7:0]     wdata = 8'h00;
   logic [7:0]     rdata;
   logic [NCH-1:0] ch_tick;
   logic           irq;

   tick_scheduler #(.NCH(NCH)) dut (
      .clk(clk), .reset(reset), .tick_in(tick_in), .wr(wr), .rd(rd),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ch_tick(ch_tick), .irq(irq)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: a channel is "running" with some number of ticks left before it fires.
   bit             m_run [NCH];
   int             m_left [NCH];
   int             m_reload [NCH];
   bit             m_os [NCH];
   bit             m_ie [NCH];
   bit             m_exp [NCH];
   logic [7:0]     m_rdata = 8'h00;
   logic [NCH-1:0] m_tick = '0;
   logic           m_irq = 1'b0;

   bit chk_en = 1'b0;
   int cyc = 0;
   int pulses [NCH];
   int last_p [NCH];
   int prev_p [NCH];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_read(input logic [AW-1:0] a);
      int c;
      c = int'(a >> 2);
      if (c >= NCH) return 8'h00;
      case (a[1:0])
         2'd0:    return 8'(m_reload[c] % 256);
         2'd1:    return 8'(m_reload[c] / 256);
         2'd2:    return {5'b0, m_ie[c], m_os[c], m_run[c]};
         default: return {7'b0, m_exp[c]};
      endcase
   endfunction

   task automatic m_step();
      bit here, was_run;
      int rg;
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            m_run[c] = 0; m_left[c] = 0; m_reload[c] = 0;
            m_os[c] = 0; m_ie[c] = 0; m_exp[c] = 0;
         end
         m_rdata = 8'h00; m_tick = '0; m_irq = 1'b0;
         return;
      end
      m_irq = 1'b0;
      for (int c = 0; c < NCH; c++) if (m_exp[c] && m_ie[c]) m_irq = 1'b1;
      if (rd) m_rdata = m_read(addr);
      rg = int'(addr[1:0]);
      for (int c = 0; c < NCH; c++) begin
         here    = wr && (int'(addr >> 2) == c);
         was_run = m_run[c];
         m_tick[c] = 1'b0;
         if (here && rg == 3 && wdata[0]) m_exp[c] = 0;
         if (was_run && tick_in && !(here && rg == 2 && !wdata[0])) begin
            if (m_left[c] > 0) m_left[c]--;
            else begin
               m_tick[c] = 1'b1;
               m_exp[c]  = 1;
               if (m_os[c]) m_run[c] = 0;
               else         m_left[c] = m_reload[c];
            end
         end
         if (here) begin
            case (rg)
               0: m_reload[c] = (m_reload[c] / 256) * 256 + int'(wdata);
               1: m_reload[c] = (m_reload[c] % 256) + int'(wdata) * 256;
               2: begin
                  m_os[c] = wdata[1];
                  m_ie[c] = wdata[2];
                  if (!wdata[0]) m_run[c] = 0;
                  else if (!was_run) begin
                     m_run[c]  = 1;
                     m_left[c] = m_reload[c];
                  end
               end
               default: ;
            endcase
         end
      end
   endtask

   // Single compare process: outputs against the model every cycle, plus pulse bookkeeping.
   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         chk("rdata", rdata, m_rdata);
         chk("ch_tick", ch_tick, m_tick);
         chk("irq", irq, m_irq);
      end
      for (int c = 0; c < NCH; c++) begin
         if (ch_tick[c] === 1'b1) begin
            pulses[c]++;
            prev_p[c] = last_p[c];
            last_p[c] = cyc;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      m_step();
      @(negedge clk);
   endtask

   task automatic wr_reg(input int a, input int d);
      wr = 1'b1; addr = AW'(a); wdata = 8'(d);
      step();
      wr = 1'b0;
   endtask

   task automatic rd_reg(input int a, output logic [7:0] d);
      rd = 1'b1; addr = AW'(a);
      step();
      rd = 1'b0;
      d = rdata;
   endtask

   task automatic run_ticks(input int n, input int per);
      for (int k = 0; k < n; k++) begin
         tick_in = 1'b1;
         step();
         tick_in = 1'b0;
         for (int j = 1; j < per; j++) step();
      end
   endtask

   initial begin
      logic [7:0] v;
      int p;
      for (int c = 0; c < NCH; c++) begin pulses[c] = 0; last_p[c] = 0; prev_p[c] = 0; end

      step();
      chk_en = 1'b1;
      step();
      chk("rst_rdata", rdata, 8'h00);
      chk("rst_ch_tick", ch_tick, 0);
      chk("rst_irq", irq, 1'b0);
      reset = 1'b0;
      step();

      // Ch0 periodic, RELOAD=3, tick every 4 clks -> pulse every 16 clks
      wr_reg(0, 3); wr_reg(1, 0); wr_reg(2, 8'h01);
      p = pulses[0];
      run_ticks(16, 4);
      chk("t1_pulse_count", pulses[0] - p, 4);
      chk("t1_pulse_gap", last_p[0] - prev_p[0], 16);
      rd_reg(3, v);
      chk("t1_status0", v, 8'h01);
      wr_reg(2, 0); wr_reg(3, 1);

      // Ch1 one-shot RELOAD=0 -> exactly one pulse, EN self-clears
      wr_reg(4, 0); wr_reg(5, 0); wr_reg(6, 8'h03);
      p = pulses[1];
      run_ticks(6, 3);
      chk("t2_pulse_count", pulses[1] - p, 1);
      rd_reg(6, v);
      chk("t2_ctrl1", v, 8'h02);

      // Ch2 IE+EN, RELOAD=1 -> irq one clk after EXPIRED, W1C drops it
      wr_reg(8, 1); wr_reg(9, 0); wr_reg(10, 8'h05);
      run_ticks(1, 2);
      tick_in = 1'b1; step(); tick_in = 1'b0;
      chk("t3_tick2", ch_tick[2], 1'b1);
      chk("t3_irq_lat", irq, 1'b0);
      step();
      chk("t3_irq_set", irq, 1'b1);
      wr_reg(11, 1);
      chk("t3_irq_hold", irq, 1'b1);
      step();
      chk("t3_irq_clr", irq, 1'b0);
      wr_reg(10, 0);

      // W1C on ch0 in the same clk it expires: set wins
      wr_reg(2, 8'h05);
      run_ticks(4, 2);
      chk("t4_irq_first", irq, 1'b1);
      run_ticks(3, 2);
      tick_in = 1'b1; wr = 1'b1; addr = AW'(3); wdata = 8'h01;
      step();
      tick_in = 1'b0; wr = 1'b0;
      chk("t4_tick0", ch_tick[0], 1'b1);
      step();
      rd_reg(3, v);
      chk("t4_status0", v, 8'h01);
      chk("t4_irq", irq, 1'b1);

      // Ch3 disabled on its expiry clk -> no pulse; re-enable -> pulse after 11 ticks
      wr_reg(12, 10); wr_reg(13, 0); wr_reg(14, 8'h01);
      p = pulses[3];
      run_ticks(10, 2);
      tick_in = 1'b1; wr = 1'b1; addr = AW'(14); wdata = 8'h00;
      step();
      tick_in = 1'b0; wr = 1'b0;
      step(); step();
      chk("t5_no_pulse", pulses[3] - p, 0);
      rd_reg(15, v);
      chk("t5_status3", v, 8'h00);
      wr_reg(14, 8'h01);
      p = pulses[3];
      run_ticks(10, 2);
      chk("t5_not_yet", pulses[3] - p, 0);
      run_ticks(1, 2);
      chk("t5_eleventh", pulses[3] - p, 1);

      // Reset mid-count with everything running and a tick in flight
      wr_reg(0, 0); wr_reg(4, 2); wr_reg(6, 8'h01); wr_reg(8, 1); wr_reg(10, 8'h01);
      run_ticks(3, 2);
      chk("t6_irq_pre", irq, 1'b1);
      reset = 1'b1; tick_in = 1'b1;
      step();
      reset = 1'b0; tick_in = 1'b0;
      chk("t6_ch_tick", ch_tick, 0);
      chk("t6_irq", irq, 1'b0);
      for (int a = 0; a < (1 << AW); a++) begin
         rd_reg(a, v);
         chk("t6_reg_zero", v, 8'h00);
      end

      // Random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         reset   = ($urandom_range(0, 599) == 0);
         tick_in = 1'($urandom_range(0, 1));
         wr      = ($urandom_range(0, 3) == 0);
         rd      = ($urandom_range(0, 2) == 0);
         addr    = AW'($urandom_range(0, (1 << AW) - 1));
         case (addr[1:0])
            2'd0:    wdata = 8'($urandom_range(0, 6));
            2'd1:    wdata = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 2)) : 8'h00;
            default: wdata = 8'($urandom);
         endcase
         step();
      end
      reset = 1'b0; tick_in = 1'b0; wr = 1'b0; rd = 1'b0;
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
